// File: rtl/game_mixer_pkg.sv
// game_mixer_pkg
// Shared types and constants for the game layer mixer.
//   prio_table_t  : slot -> layer map, sized for the largest supported layer
//                   count (16); slots/layers beyond N_LAYERS are inert.
//   mixer_state_e : end-of-game sequencer state (PLAY, END).
//   OVL_*_BIT     : overlay colour bit positions (the MSB is always RGB_W-1).
package game_mixer_pkg;

  localparam int MAX_LAYERS = 16;
  localparam int IDX_W      = 4;

  typedef logic [IDX_W-1:0] layer_idx_t;
  typedef layer_idx_t [MAX_LAYERS-1:0] prio_table_t;

  typedef enum logic {
    PLAY = 1'b0,
    END  = 1'b1
  } mixer_state_e;

  localparam int OVL_WON_BIT = 1;  // carries ~won
  localparam int OVL_RND_BIT = 0;  // carries the aligned noise bit

  // Slot i -> layer i: reproduces plain index priority.
  function automatic prio_table_t identity_table();
    prio_table_t t;
    for (int i = 0; i < MAX_LAYERS; i++) t[i] = layer_idx_t'(i);
    return t;
  endfunction

endpackage

// File: rtl/game_layer_mixer_if.sv
// game_layer_mixer_if
// Pixel/control bundle between the sprite engines, the game FSM and the mixer.
//   master : drives frame_start, pixel_valid, layer_en, layer_rgb, bg_rgb,
//            prio_wr/prio_slot/prio_layer, game_over, game_won, random.
//   slave  : the mixer; drives rgb, rgb_valid, end_active, end_done and the
//            debug copy of its sequencer state.
// Handshake: no backpressure. pixel_valid qualifies the pixel of the current
// cycle; rgb_valid qualifies rgb, which trails its inputs by exactly 2 cycles.
interface game_layer_mixer_if #(
  parameter int N_LAYERS = 8,
  parameter int RGB_W    = 3
);
  import game_mixer_pkg::*;

  localparam int SLOT_W = $clog2(N_LAYERS);

  logic                      frame_start;
  logic                      pixel_valid;
  logic [N_LAYERS-1:0]       layer_en;
  logic [N_LAYERS*RGB_W-1:0] layer_rgb;
  logic [RGB_W-1:0]          bg_rgb;
  logic                      prio_wr;
  logic [SLOT_W-1:0]         prio_slot;
  logic [SLOT_W-1:0]         prio_layer;
  logic                      game_over;
  logic                      game_won;
  logic                      random;
  logic [RGB_W-1:0]          rgb;
  logic                      rgb_valid;
  logic                      end_active;
  logic                      end_done;
  mixer_state_e              state;

  modport master (
    output frame_start, pixel_valid, layer_en, layer_rgb, bg_rgb,
           prio_wr, prio_slot, prio_layer, game_over, game_won, random,
    input  rgb, rgb_valid, end_active, end_done, state
  );

  modport slave (
    input  frame_start, pixel_valid, layer_en, layer_rgb, bg_rgb,
           prio_wr, prio_slot, prio_layer, game_over, game_won, random,
    output rgb, rgb_valid, end_active, end_done, state
  );

endinterface

// File: rtl/game_prio_select.sv
// game_prio_select
// Combinational priority encoder over table slots.
//   hit_vec    : per-slot hit flags (slot 0 = highest priority)
//   prio_table : slot -> layer map the hits were computed against
//   found      : some slot hit
//   layer      : layer index held by the lowest hitting slot (0 if none)
module game_prio_select
  import game_mixer_pkg::*;
(
  input  logic [MAX_LAYERS-1:0] hit_vec,
  input  prio_table_t           prio_table,
  output logic                  found,
  output layer_idx_t            layer
);

  // Scan from the lowest priority upward so the lowest slot wins.
  always_comb begin
    found = 1'b0;
    layer = '0;
    for (int s = MAX_LAYERS - 1; s >= 0; s--) begin
      if (hit_vec[s]) begin
        found = 1'b1;
        layer = prio_table[s];
      end
    end
  end

endmodule

// File: rtl/game_layer_mixer.sv
// game_layer_mixer
// Per-pixel compositor: N sprite layers + background under a double-buffered
// priority table, plus the end-of-game overlay sequencer.
//   clk, rst : pixel clock, asynchronous active-high reset
//   bus      : game_layer_mixer_if.slave (pixel inputs, table writes,
//              game_over/game_won/random in; rgb, rgb_valid, end_active,
//              end_done, state out)
// Optional feature: define GAME_MIXER_BLINK_EN to blink the overlay with a
// half-period of BLINK_FRAMES frames; otherwise it is solid for all of END.
// Pipeline: stage 1 registers inputs + per-slot hits, stage 2 registers the
// encoded pixel; 2 cycles latency, 1 pixel/clk.
module game_layer_mixer
  import game_mixer_pkg::*;
#(
  parameter int N_LAYERS     = 8,
  parameter int RGB_W        = 3,
  parameter int END_FRAMES   = 60,
  parameter int BLINK_FRAMES = 8
) (
  input logic               clk,
  input logic               rst,
  game_layer_mixer_if.slave bus
);

  localparam int CNT_W = (END_FRAMES > 1) ? $clog2(END_FRAMES) : 1;

  // ---------------- priority table (shadow + active) ----------------
  prio_table_t shadow_q, shadow_d, active_q;

  always_comb begin
    shadow_d = shadow_q;
    if (bus.prio_wr) shadow_d[layer_idx_t'(bus.prio_slot)] = layer_idx_t'(bus.prio_layer);
  end

  // Commit uses shadow_d so a write in the frame_start cycle is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= identity_table();
      active_q <= identity_table();
    end else begin
      shadow_q <= shadow_d;
      if (bus.frame_start) active_q <= shadow_d;
    end
  end

  // ---------------- end-of-game sequencer ----------------
  mixer_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             won_q, won_d;
  logic             end_done;
  logic             show;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PLAY;
      cnt_q   <= '0;
      won_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      won_q   <= won_d;
    end
  end

  // end_done fires in the frame_start cycle that completes the count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    won_d    = won_q;
    end_done = 1'b0;
    case (state_q)
      PLAY: begin
        if (bus.game_over) begin
          won_d   = bus.game_won;
          cnt_d   = '0;
          state_d = END;
        end
      end
      END: begin
        if (bus.frame_start) begin
          if (cnt_q == CNT_W'(END_FRAMES - 1)) begin
            end_done = 1'b1;
            cnt_d    = '0;
            state_d  = PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = PLAY;
    endcase
  end

`ifdef GAME_MIXER_BLINK_EN
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic               phase_q;

  // Held at "shown" outside END so every sequence starts with the overlay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (state_q != END) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (bus.frame_start) begin
      if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  assign show = phase_q;
`else
  assign show = 1'b1;
`endif

  // ---------------- stage 1 ----------------
  logic [MAX_LAYERS-1:0] en_pad, hit_d;

  // Padding layer_en with zeros makes table entries >= N_LAYERS never hit.
  always_comb begin
    en_pad               = '0;
    en_pad[N_LAYERS-1:0] = bus.layer_en;
    hit_d                = '0;
    for (int s = 0; s < MAX_LAYERS; s++) hit_d[s] = en_pad[active_q[s]];
  end

  logic                      s1_valid, s1_rnd, s1_ovl;
  logic [MAX_LAYERS-1:0]     s1_hit;
  prio_table_t               s1_table;
  logic [N_LAYERS*RGB_W-1:0] s1_rgb;
  logic [RGB_W-1:0]          s1_bg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_hit   <= '0;
      s1_table <= '0;
      s1_rgb   <= '0;
      s1_bg    <= '0;
      s1_rnd   <= 1'b0;
      s1_ovl   <= 1'b0;
    end else begin
      s1_valid <= bus.pixel_valid;
      s1_hit   <= hit_d;
      s1_table <= active_q;
      s1_rgb   <= bus.layer_rgb;
      s1_bg    <= bus.bg_rgb;
      s1_rnd   <= bus.random;
      s1_ovl   <= (state_q == END) && show;
    end
  end

  // ---------------- stage 2 ----------------
  logic             sel_found;
  layer_idx_t       sel_layer;
  logic [RGB_W-1:0] rgb_pad [MAX_LAYERS];
  logic [RGB_W-1:0] ovl, px_d, rgb_q;
  logic             rgb_valid_q;

  game_prio_select u_sel (
    .hit_vec    (s1_hit),
    .prio_table (s1_table),
    .found      (sel_found),
    .layer      (sel_layer)
  );

  for (genvar i = 0; i < MAX_LAYERS; i++) begin : g_pad
    if (i < N_LAYERS) begin : g_real
      assign rgb_pad[i] = s1_rgb[i*RGB_W +: RGB_W];
    end else begin : g_zero
      assign rgb_pad[i] = '0;
    end
  end

  // won_q only changes on entry to END, so it is stable for every pixel
  // that carries s1_ovl.
  always_comb begin
    ovl              = '0;
    ovl[RGB_W-1]     = 1'b1;
    ovl[OVL_WON_BIT] = ~won_q;
    ovl[OVL_RND_BIT] = s1_rnd;
    if (!s1_valid)      px_d = '0;
    else if (s1_ovl)    px_d = ovl;
    else if (sel_found) px_d = rgb_pad[sel_layer];
    else                px_d = s1_bg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      rgb_q       <= px_d;
      rgb_valid_q <= s1_valid;
    end
  end

  assign bus.rgb        = rgb_q;
  assign bus.rgb_valid  = rgb_valid_q;
  assign bus.end_active = (state_q == END);
  assign bus.end_done   = end_done;
  assign bus.state      = state_q;

endmodule

// File: doc/game_layer_mixer.md
# game_layer_mixer

Parametrised per-pixel compositor for the 2D game pipeline: merges N sprite layers plus a background colour into one pixel stream under a runtime-programmable priority table. Owns the end-of-game overlay sequence (frame-counted, optionally blinking), so the game FSM only pulses `game_over`. Sits between the sprite engines and the display output register, replacing the fixed-priority mixer.

## Interface
- `N_LAYERS`, 8: sprite layer count, 2..16
- `RGB_W`, 3: pixel width, ≥3
- `END_FRAMES`, 60: frames the end-of-game overlay lasts, ≥1
- `BLINK_FRAMES`, 8: frames per blink half-period, ≥1; used only with `GAME_MIXER_BLINK_EN`
- `clk`  in  1  pixel clock
- `rst`  in  1  reset, asynchronous, active-high
- `frame_start`  in  1  one-cycle pulse coincident with the first pixel of a frame
- `pixel_valid`  in  1  the current cycle carries an active pixel
- `layer_en`  in  N_LAYERS  per-layer opaque flag
- `layer_rgb`  in  N_LAYERS*RGB_W  packed colours; layer i at bits [i*RGB_W +: RGB_W]
- `bg_rgb`  in  RGB_W  colour when no enabled layer is hit
- `prio_wr`  in  1  write strobe for the priority table
- `prio_slot`  in  $clog2(N_LAYERS)  slot written; slot 0 has highest priority
- `prio_layer`  in  $clog2(N_LAYERS)  layer index stored into that slot
- `game_over`  in  1  pulse that starts the end sequence
- `game_won`  in  1  sampled together with `game_over`
- `random`  in  1  per-pixel noise bit
- `rgb`  out  RGB_W  composited pixel
- `rgb_valid`  out  1  `pixel_valid` delayed to align with `rgb`
- `end_active`  out  1  end sequence running
- `end_done`  out  1  one-cycle pulse when the end sequence finishes

## Operation
- Priority table has two copies: shadow and active. `prio_wr` writes the shadow copy. The active copy loads from the shadow copy on `frame_start`, so priorities never change mid-frame.
- A write and a `frame_start` in the same cycle: the written value is included in that commit.
- Reset value of both copies: slot i = layer i, which reproduces fixed index priority.
- Duplicate entries are legal; a layer listed in no slot is never displayed.
- Selection: the lowest slot s whose `layer_en[table[s]]` is set supplies `layer_rgb[table[s]]`. If no slot qualifies, the output is `bg_rgb`.
- If `pixel_valid` was low for the pixel, `rgb` = 0.
- FSM states:
  - PLAY: on `game_over`, latch `won` = `game_won`, clear the frame counter, go to END.
  - END: increment the frame counter on each `frame_start`. When the count reaches END_FRAMES, pulse `end_done` in that cycle and return to PLAY.
  - `game_over` during END is ignored.
- Overlay colour: MSB = 1, bit 1 = ~won, bit 0 = `random` (pipeline-aligned), other bits = 0. While in END and the overlay is shown, it replaces every valid pixel, including the background.
- `end_active` = 1 exactly while in END.
- Reset values: `rgb` = 0, `rgb_valid` = 0, `end_active` = 0, `end_done` = 0, FSM = PLAY, counters = 0.
- Reset mid-sequence aborts the sequence with no `end_done` pulse.

## Timing
- Two-stage pipeline:
  - Stage 1 registers the inputs and the per-slot hit vector.
  - Stage 2 registers the priority-encoded result.
  - Latency from inputs to `rgb`/`rgb_valid` is 2 cycles; throughput is 1 pixel/clk with no stalls.
- The overlay decision uses the FSM state sampled in stage 1, so the overlay starts on the pixel presented 1 cycle after `game_over` and appears at `rgb` 2 cycles later.
- A priority commit on `frame_start` applies to the pixel presented in the cycle after the `frame_start` cycle.
- The `frame_start` pixel itself uses the old table.

## Configuration
- `GAME_MIXER_BLINK_EN` defined:
  - In END, a blink counter toggles a phase bit every BLINK_FRAMES frame starts; phase starts at 1 (overlay shown).
  - When phase = 0, normal composited pixels pass through.
- Undefined: the overlay is solid for all of END; the blink counter is not built.

## Structure
- Package `game_mixer_pkg`:
  - `prio_table_t` typedef
  - FSM state enum `mixer_state_e` (PLAY, END)
  - overlay bit-position constants
- Sub-module `game_prio_select`: combinational priority encoder over slots, returning hit flag and layer index. Instantiated once in stage 2.

## Test plan
- Reset table, `layer_en` = 8'b0000_0110, layer1 = 3'b010, layer2 = 3'b001 → `rgb` = 3'b010 two cycles later.
- Write slot0 = layer 2 mid-frame → output unchanged until the pixel after the next `frame_start`, then `rgb` = 3'b001.
- `layer_en` = 0, `bg_rgb` = 3'b011, `pixel_valid` toggling → `rgb` alternates 3'b011/0, and `rgb_valid` matches `pixel_valid` delayed 2.
- `game_over` with `game_won` = 1, END_FRAMES = 3, `random` = 1 → `rgb` = 3'b101 on every valid pixel. `end_done` pulses on the 3rd `frame_start`, and a second `game_over` pulse is ignored.
- With BLINK_EN and BLINK_FRAMES = 1, END_FRAMES = 4 → overlay shows in frames 1 and 3; composited pixels show in frames 2 and 4.
- Assert `rst` 2 frames into END → `end_active` drops immediately, no `end_done`, and the table returns to the identity mapping.
